effect_bypass_xfade: RTL and testbench

Multi-channel effect-slot wrapper that time-aligns the dry signal with an effect's wet output and crossfades between them when the slot is enabled or bypassed. This removes the clicks that a hard dry/wet switch produces. It sits around any fixed-latency effect in the chain: the effect and this block both receive the same input, and this block produces the slot output.

---
 rtl/audio_fx_pkg.sv | 28 ++
 rtl/xfade_delay_line.sv | 52 +++++
 rtl/effect_bypass_xfade.sv | 183 ++++++++++++++++++
 tb/tb_effect_bypass_xfade.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_fx_pkg
//  Purpose  : Shared types and helpers for the effect-slot crossfade wrapper.
//             Holds the slot state encoding and the mix-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package audio_fx_pkg;

    // Slot state: dry, ramping to wet, fully wet, ramping back to dry
    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        FADE_IN  = 2'd1,
        ACTIVE   = 2'd2,
        FADE_OUT = 2'd3
    } xfade_state_t;

    // Headroom above the sample width: one bit for the unsigned gain weight,
    // one for the sum of the two weighted products
    localparam int MIX_GUARD_BITS = 2;

    // Width of the signed per-channel products and their sum
    function automatic int mix_width(input int data_width, input int fade_log2);
        return data_width + fade_log2 + MIX_GUARD_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xfade_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : xfade_delay_line
//  Purpose  : Fixed-latency shift register carrying a data word plus its
//             valid strobe. LATENCY = 0 degenerates to plain wiring.
//             Synchronous active-low reset flushes every stage to zero.
//  Revision : 1.0  initial release
// ============================================================================
module xfade_delay_line #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    if (LATENCY == 0) begin : g_passthru
        logic w_unused;
        assign w_unused = &{1'b0, clk, reset_n};
        assign o_data   = i_data;
        assign o_valid  = i_valid;
    end else begin : g_shift
        logic [WIDTH-1:0]   r_data [LATENCY];
        logic [LATENCY-1:0] r_valid;

        // Shift data and strobe one stage per clock; reset discards in-flight samples
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int i = 0; i < LATENCY; i++) begin
                    r_data[i] <= '0;
                end
                r_valid <= '0;
            end else begin
                r_data[0]  <= i_data;
                r_valid[0] <= i_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    r_data[i]  <= r_data[i-1];
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end

        assign o_data  = r_data[LATENCY-1];
        assign o_valid = r_valid[LATENCY-1];
    end

endmodule
`default_nettype wire

// File: rtl/effect_bypass_xfade.sv
`default_nettype none
// ============================================================================
//  Module   : effect_bypass_xfade
//  Purpose  : Effect-slot wrapper. Delays the dry signal to line up with the
//             effect output, then mixes dry/wet with a shared gain G that
//             ramps 0..2^FADE_LOG2 over one sample per step on enable/bypass.
//  Options  : EFFECT_XFADE_EN - when defined, crossfade ramps are built;
//             otherwise the output is a hard dry/wet select (no multipliers).
//  Revision : 1.0  initial release
// ============================================================================
module effect_bypass_xfade
    import audio_fx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int LATENCY    = 1,
    parameter int FADE_LOG2  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         bypass,
    input  logic                         sample_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] audio_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wet_in,
    input  logic                         wet_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] audio_out,
    output logic                         audio_out_valid,
    output logic                         fading,
    output logic                         wet_err
);

    localparam int c_W = CHANNELS * DATA_WIDTH;

    logic [c_W-1:0] w_dry_d;
    logic           w_dv;
    logic [c_W-1:0] w_mix;
    logic [c_W-1:0] r_audio_out;
    logic           r_out_valid;
    logic           r_wet_err;

    xfade_delay_line #(
        .WIDTH   (c_W),
        .LATENCY (LATENCY)
    ) u_dry_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (audio_in),
        .i_valid (sample_valid),
        .o_data  (w_dry_d),
        .o_valid (w_dv)
    );

`ifdef EFFECT_XFADE_EN
    localparam int              c_MW = mix_width(DATA_WIDTH, FADE_LOG2);
    localparam logic [FADE_LOG2:0] c_N = {1'b1, {FADE_LOG2{1'b0}}};

    xfade_state_t       r_state;
    xfade_state_t       w_state_nxt;
    logic [FADE_LOG2:0] r_gain;
    logic [FADE_LOG2:0] w_gain_nxt;
    logic [FADE_LOG2:0] w_gain_up;
    logic [FADE_LOG2:0] w_gain_dn;
    logic [FADE_LOG2:0] w_inv_gain;
    logic               r_fading;
    logic signed [c_MW-1:0] w_k_dry;
    logic signed [c_MW-1:0] w_k_wet;

    assign w_gain_up  = r_gain + 1'b1;
    assign w_gain_dn  = r_gain - 1'b1;
    assign w_inv_gain = c_N - r_gain;
    assign w_k_dry    = {{(c_MW-FADE_LOG2-1){1'b0}}, w_inv_gain};
    assign w_k_wet    = {{(c_MW-FADE_LOG2-1){1'b0}}, r_gain};

    // Next state/gain: step G one unit toward 0 (bypass) or N (active);
    // a reversal mid-ramp just changes direction, so G never jumps
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        case (r_state)
            BYPASS: begin
                if (!bypass) begin
                    w_state_nxt = FADE_IN;
                    w_gain_nxt  = w_gain_up;
                end
            end
            FADE_IN, FADE_OUT: begin
                if (!bypass) begin
                    w_gain_nxt  = w_gain_up;
                    w_state_nxt = (w_gain_up == c_N) ? ACTIVE : FADE_IN;
                end else begin
                    w_gain_nxt  = w_gain_dn;
                    w_state_nxt = (w_gain_dn == '0) ? BYPASS : FADE_OUT;
                end
            end
            ACTIVE: begin
                if (bypass) begin
                    w_state_nxt = FADE_OUT;
                    w_gain_nxt  = w_gain_dn;
                end
            end
            default: begin
                w_state_nxt = BYPASS;
                w_gain_nxt  = '0;
            end
        endcase
    end

    // Advance state and gain once per aligned dry sample
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= BYPASS;
            r_gain   <= '0;
            r_fading <= 1'b0;
        end else if (w_dv) begin
            r_state  <= w_state_nxt;
            r_gain   <= w_gain_nxt;
            r_fading <= (w_state_nxt == FADE_IN) || (w_state_nxt == FADE_OUT);
        end
    end

    assign fading = r_fading;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] w_dry;
        logic signed [DATA_WIDTH-1:0] w_wet;
        logic signed [c_MW-1:0]       w_dry_x;
        logic signed [c_MW-1:0]       w_wet_x;
        logic signed [c_MW-1:0]       w_sum;
        logic                         w_unused_bits;

        assign w_dry   = w_dry_d[ch*DATA_WIDTH +: DATA_WIDTH];
        assign w_wet   = wet_in[ch*DATA_WIDTH +: DATA_WIDTH];
        assign w_dry_x = {{(c_MW-DATA_WIDTH){w_dry[DATA_WIDTH-1]}}, w_dry};
        assign w_wet_x = {{(c_MW-DATA_WIDTH){w_wet[DATA_WIDTH-1]}}, w_wet};
        assign w_sum   = (w_dry_x * w_k_dry) + (w_wet_x * w_k_wet);
        // Dropping the low FADE_LOG2 bits of a two's-complement value is an
        // arithmetic shift (floor); the convex mix always fits back in DATA_WIDTH
        assign w_mix[ch*DATA_WIDTH +: DATA_WIDTH] = w_sum[FADE_LOG2 +: DATA_WIDTH];
        assign w_unused_bits = ^{w_sum[c_MW-1 -: 2], w_sum[FADE_LOG2-1:0]};
    end
`else
    logic r_wet_sel;

    // Hard switch: remember whether the next sample should come from the effect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wet_sel <= 1'b0;
        end else if (w_dv) begin
            r_wet_sel <= ~bypass;
        end
    end

    assign fading = 1'b0;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        assign w_mix[ch*DATA_WIDTH +: DATA_WIDTH] = r_wet_sel ?
            wet_in[ch*DATA_WIDTH +: DATA_WIDTH] : w_dry_d[ch*DATA_WIDTH +: DATA_WIDTH];
    end
`endif

    // Registered mix stage plus sticky wet/dry strobe disagreement flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_audio_out <= '0;
            r_out_valid <= 1'b0;
            r_wet_err   <= 1'b0;
        end else begin
            r_out_valid <= w_dv;
            if (w_dv) begin
                r_audio_out <= w_mix;
            end
            if (w_dv != wet_valid) begin
                r_wet_err <= 1'b1;
            end
        end
    end

    assign audio_out       = r_audio_out;
    assign audio_out_valid = r_out_valid;
    assign wet_err         = r_wet_err;

endmodule
`default_nettype wire

// File: tb/tb_effect_bypass_xfade.sv
`default_nettype none
// ============================================================================
//  Module   : tb_effect_bypass_xfade
//  Purpose  : Self-checking bench for effect_bypass_xfade. A reference model
//             delays dry samples in a queue, moves G one step toward its
//             target per aligned sample and mixes with integer arithmetic.
//  Options  : EFFECT_XFADE_EN selects ramped or hard-switch expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_effect_bypass_xfade;

    localparam int DW  = 32;
    localparam int CH  = 2;
    localparam int LAT = 3;
    localparam int FL  = 2;
    localparam int N   = 1 << FL;
    localparam int W   = CH * DW;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         bypass;
    logic         sample_valid;
    logic [W-1:0] audio_in;
    logic [W-1:0] wet_in;
    logic         wet_valid;
    logic [W-1:0] audio_out;
    logic         audio_out_valid;
    logic         fading;
    logic         wet_err;

    always #5 clk = ~clk;

    effect_bypass_xfade #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .LATENCY    (LAT),
        .FADE_LOG2  (FL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bypass          (bypass),
        .sample_valid    (sample_valid),
        .audio_in        (audio_in),
        .wet_in          (wet_in),
        .wet_valid       (wet_valid),
        .audio_out       (audio_out),
        .audio_out_valid (audio_out_valid),
        .fading          (fading),
        .wet_err         (wet_err)
    );

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } smp_t;

    smp_t         hist[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_out;
    logic         exp_valid;
    logic         exp_fading;
    logic         exp_err;
    int           g;
    logic         last_dv;
    int           cap_q[$];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mix1(input logic [DW-1:0] d, input logic [DW-1:0] w,
                                          input int gg);
        longint m;
        m = longint'($signed(d)) * longint'(N - gg) + longint'($signed(w)) * longint'(gg);
        return DW'(m >>> FL);
    endfunction

    function automatic logic [W-1:0] pair(input int a);
        logic [DW-1:0] s;
        s = DW'(a);
        return {s, s};
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        case ($urandom % 8)
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back('0);
        exp_out    = '0;
        exp_valid  = 1'b0;
        exp_fading = 1'b0;
        exp_err    = 1'b0;
        g          = 0;
        last_dv    = 1'b0;
    endtask

    // Reference behaviour at one rising edge, using the inputs presented to it
    task automatic model_edge();
        logic         dv;
        logic [W-1:0] dry;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (LAT == 0) begin
            dv  = sample_valid;
            dry = audio_in;
        end else begin
            dv  = hist[0].v;
            dry = hist[0].d;
        end
        exp_valid = dv;
        if (dv !== wet_valid) exp_err = 1'b1;
        if (dv) begin
            for (int c = 0; c < CH; c++)
                exp_out[c*DW +: DW] = mix1(dry[c*DW +: DW], wet_in[c*DW +: DW], g);
`ifdef EFFECT_XFADE_EN
            begin
                int tgt;
                tgt = bypass ? 0 : N;
                if (tgt > g) g++;
                else if (tgt < g) g--;
                exp_fading = (g != 0) && (g != N);
            end
`else
            g          = bypass ? 0 : N;
            exp_fading = 1'b0;
`endif
        end
        if (LAT > 0) begin
            void'(hist.pop_front());
            hist.push_back({sample_valid, audio_in});
        end
        last_dv = dv;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_eq("out",     64'(audio_out),       64'(exp_out));
        chk_eq("valid",   64'(audio_out_valid), 64'(exp_valid));
        chk_eq("fading",  64'(fading),          64'(exp_fading));
        chk_eq("wet_err", 64'(wet_err),         64'(exp_err));
        if (audio_out_valid) cap_q.push_back(int'($signed(audio_out[DW-1:0])));
    endtask

    task automatic put(input logic v, input logic [W-1:0] dry, input logic [W-1:0] wet,
                       input logic byp, input logic late);
        sample_valid = v;
        audio_in     = dry;
        wet_in       = wet;
        bypass       = byp;
        if (late)          wet_valid = last_dv;
        else if (LAT == 0) wet_valid = v;
        else               wet_valid = hist[0].v;
        cycle();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) put(1'b1, {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()},
                                         1'($urandom % 2), 1'b0);
        reset_n = 1'b1;
        chk_eq("rst_out",   64'(audio_out),       64'd0);
        chk_eq("rst_valid", 64'(audio_out_valid), 64'd0);
        chk_eq("rst_fading",64'(fading),          64'd0);
        chk_eq("rst_err",   64'(wet_err),         64'd0);
    endtask

    // Captured ch0 outputs: leading dry values, then the listed sequence
    task automatic chk_pattern(input string tag, input int pat[6]);
        int idx;
        int found;
        idx   = -1;
        found = 0;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (found == 0 && cap_q[i] != 1000) begin
                idx   = i;
                found = 1;
            end
        end
        chk_eq({tag, "_found"}, 64'(found), 64'd1);
        if (found == 1) begin
            chk_eq({tag, "_lead"}, 64'(cap_q[0]), 64'(1000));
            for (int k = 0; k < 6; k++) begin
                if (idx + k < cap_q.size())
                    chk_eq($sformatf("%s_%0d", tag, k), 64'(cap_q[idx+k]), 64'(pat[k]));
                else
                    chk_eq($sformatf("%s_%0d_missing", tag, k), 64'(cap_q.size()), 64'(idx + k + 1));
            end
        end
    endtask

    initial begin
        int n;
        int fade_pat[6];
        int rev_pat[6];
        logic byp;
`ifdef EFFECT_XFADE_EN
        fade_pat = '{500, 0, -500, -1000, -1000, -1000};
        rev_pat  = '{500, 0, 500, 1000, 1000, 1000};
`else
        fade_pat = '{-1000, -1000, -1000, -1000, -1000, -1000};
        rev_pat  = '{-1000, -1000, 1000, 1000, 1000, 1000};
`endif
        reset_n      = 1'b0;
        bypass       = 1'b1;
        sample_valid = 1'b0;
        audio_in     = '0;
        wet_in       = '0;
        wet_valid    = 1'b0;
        model_reset();

        do_reset(2);

        // Single pulse: output strobe LAT+1 cycles later, wet strobe aligned
        put(1'b1, pair(123), pair(-77), 1'b1, 1'b0);
        n = 1;
        while (!audio_out_valid && n < 20) begin
            put(1'b0, '0, '0, 1'b1, 1'b0);
            n++;
        end
        chk_eq("latency", 64'(n), 64'(LAT + 1));
        chk_eq("lat_err", 64'(wet_err), 64'd0);
        put(1'b0, '0, '0, 1'b1, 1'b0);
        put(1'b0, '0, '0, 1'b1, 1'b0);

        // Fade-in from dry 1000 to wet -1000
        do_reset(1);
        cap_q.delete();
        for (int i = 0; i < 6; i++)  put(1'b1, pair(1000), pair(-1000), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) put(1'b1, pair(1000), pair(-1000), 1'b0, 1'b0);
        chk_pattern("fadein", fade_pat);

        // Reversal after two enabled samples
        do_reset(1);
        cap_q.delete();
        for (int i = 0; i < 6; i++) put(1'b1, pair(1000), pair(-1000), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) put(1'b1, pair(1000), pair(-1000), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) put(1'b1, pair(1000), pair(-1000), 1'b1, 1'b0);
        chk_pattern("reverse", rev_pat);
        chk_eq("rev_fading", 64'(fading), 64'd0);

        // Late wet strobe makes the error flag stick
        do_reset(1);
        for (int i = 0; i < 10; i++)
            put(1'b1, {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, 1'b0, 1'b1);
        chk_eq("err_sticky", 64'(wet_err), 64'd1);
        for (int i = 0; i < 4; i++)
            put(1'b1, {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, 1'b1, 1'b0);
        chk_eq("err_held", 64'(wet_err), 64'd1);

        // Reset in the middle of a ramp
        do_reset(1);
        for (int i = 0; i < LAT + 2; i++)
            put(1'b1, {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, 1'b0, 1'b0);
        do_reset(1);
        for (int i = 0; i < LAT + 2; i++)
            put(1'b1, {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, 1'b1, 1'b0);

        // Bypassed: full-scale and random dry passes through bit-exact
        for (int i = 0; i < 40; i++)
            put(1'($urandom % 4 != 0), {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()},
                1'b1, 1'b0);

        // Random traffic with occasional bypass toggles and gaps
        byp = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom % 12 == 0) byp = ~byp;
            put(1'($urandom % 4 != 0), {rnd_word(), rnd_word()}, {rnd_word(), rnd_word()},
                byp, 1'b0);
        end
        for (int i = 0; i < LAT + 2; i++) put(1'b0, '0, '0, byp, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
